// File: rtl/vga_timing_pkg.sv
// Default VGA timing constants (640x480 @ 60 Hz, 25 MHz pixel clock) shared by
// the sync generator and anything downstream that needs the frame geometry.
package vga_timing_pkg;

    localparam int H_TOTAL_DEF = 800;
    localparam int H_SYNC_DEF  = 96;
    localparam int H_BACK_DEF  = 144;
    localparam int H_FRONT_DEF = 16;

    localparam int V_TOTAL_DEF = 525;
    localparam int V_SYNC_DEF  = 2;
    localparam int V_BACK_DEF  = 34;
    localparam int V_FRONT_DEF = 11;

    localparam int ACTIVE_W    = 640;
    localparam int ACTIVE_H    = 480;
    localparam int ADDR_W_DEF  = 19;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vsg_counter.sv
// Wrap counter with enable; presents its next value so the caller can register
// decoded outputs in lockstep with the count itself.
module vsg_counter #(
    parameter int MAX = 800,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt_nxt,
    output logic         tc
);

    logic [W-1:0] cnt;

    // tc marks the enabled cycle on which the count wraps back to zero.
    assign tc = en && (cnt == W'(MAX - 1));

    always_comb begin
        cnt_nxt = cnt;
        if (en) begin
            cnt_nxt = tc ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/video_sync_gen.sv
// VGA sync / blank / linear pixel-address generator.
// Define VSG_PIXEL_COORD_EN to add the registered oX/oY pixel coordinate outputs.
module video_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BACK  = H_BACK_DEF,
    parameter int H_FRONT = H_FRONT_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BACK  = V_BACK_DEF,
    parameter int V_FRONT = V_FRONT_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    output logic              oHS,
    output logic              oVS,
    output logic              oBLANK_n,
`ifdef VSG_PIXEL_COORD_EN
    output logic [9:0]        oX,
    output logic [8:0]        oY,
`endif
    output logic [ADDR_W-1:0] oADDR
);

    localparam int H_W = cnt_width(H_TOTAL);
    localparam int V_W = cnt_width(V_TOTAL);

    logic [H_W-1:0] h_nxt;
    logic [V_W-1:0] v_nxt;
    logic           h_tc;
    logic           v_tc_unused;
    logic           h_active_nxt;
    logic           v_active_nxt;
    logic           active_nxt;

    vsg_counter #(.MAX(H_TOTAL), .W(H_W)) u_h_cnt (
        .clk     (iVGA_CLK),
        .rst_n   (iRST_n),
        .en      (1'b1),
        .cnt_nxt (h_nxt),
        .tc      (h_tc)
    );

    vsg_counter #(.MAX(V_TOTAL), .W(V_W)) u_v_cnt (
        .clk     (iVGA_CLK),
        .rst_n   (iRST_n),
        .en      (h_tc),
        .cnt_nxt (v_nxt),
        .tc      (v_tc_unused)
    );

    assign h_active_nxt = (h_nxt >= H_W'(H_BACK)) && (h_nxt < H_W'(H_TOTAL - H_FRONT));
    assign v_active_nxt = (v_nxt >= V_W'(V_BACK)) && (v_nxt < V_W'(V_TOTAL - V_FRONT));
    assign active_nxt   = h_active_nxt && v_active_nxt;

    // Decoding the next count keeps the syncs aligned with the counters
    // while still leaving only flops on the output pins.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oHS      <= 1'b0;
            oVS      <= 1'b0;
            oBLANK_n <= 1'b0;
        end else begin
            oHS      <= (h_nxt >= H_W'(H_SYNC));
            oVS      <= (v_nxt >= V_W'(V_SYNC));
            oBLANK_n <= active_nxt;
        end
    end

    // The address advances after each active pixel, so it reads the current
    // pixel's index while blank_n is high; the sync overlap rearms it for a frame.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oADDR <= '0;
        end else if (!oHS && !oVS) begin
            oADDR <= '0;
        end else if (oBLANK_n) begin
            oADDR <= oADDR + 1'b1;
        end
    end

`ifdef VSG_PIXEL_COORD_EN
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oX <= '0;
            oY <= '0;
        end else if (active_nxt) begin
            oX <= 10'(h_nxt - H_W'(H_BACK));
            oY <= 9'(v_nxt - V_W'(V_BACK));
        end else begin
            oX <= '0;
            oY <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen: a shrunken-timing instance checked every cycle
// against a model, plus a default-timing instance checked at key timing points.
module tb_video_sync_gen;

    localparam int RH_TOTAL = 40;
    localparam int RH_SYNC  = 4;
    localparam int RH_BACK  = 10;
    localparam int RH_FRONT = 6;
    localparam int RV_TOTAL = 20;
    localparam int RV_SYNC  = 2;
    localparam int RV_BACK  = 5;
    localparam int RV_FRONT = 3;
    localparam int RACT_W   = RH_TOTAL - RH_BACK - RH_FRONT;
    localparam int RACT_H   = RV_TOTAL - RV_BACK - RV_FRONT;
    localparam int EXP_W    = 3 + 19 + 10 + 9;

    logic        clk;
    logic        rst_n;
    logic        rst_d_n;
    logic        hs, vs, blank_n;
    logic [18:0] addr;
    logic        hs_d, vs_d, blank_d_n;
    logic [18:0] addr_d;
`ifdef VSG_PIXEL_COORD_EN
    logic [9:0]  x, x_d;
    logic [8:0]  y, y_d;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [EXP_W-1:0] exp_q[$];

    // model state for the shrunken instance
    int          mh, mv;
    logic        mhs, mvs, mblank;
    logic [18:0] maddr;
    logic [9:0]  mx;
    logic [8:0]  my;

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    video_sync_gen #(
        .H_TOTAL(RH_TOTAL), .H_SYNC(RH_SYNC), .H_BACK(RH_BACK), .H_FRONT(RH_FRONT),
        .V_TOTAL(RV_TOTAL), .V_SYNC(RV_SYNC), .V_BACK(RV_BACK), .V_FRONT(RV_FRONT),
        .ADDR_W(19)
    ) dut (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .oHS      (hs),
        .oVS      (vs),
        .oBLANK_n (blank_n),
`ifdef VSG_PIXEL_COORD_EN
        .oX       (x),
        .oY       (y),
`endif
        .oADDR    (addr)
    );

    video_sync_gen dut_def (
        .iVGA_CLK (clk),
        .iRST_n   (rst_d_n),
        .oHS      (hs_d),
        .oVS      (vs_d),
        .oBLANK_n (blank_d_n),
`ifdef VSG_PIXEL_COORD_EN
        .oX       (x_d),
        .oY       (y_d),
`endif
        .oADDR    (addr_d)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst_live);
        if (!rst_live) begin
            mh = 0; mv = 0; mhs = 1'b0; mvs = 1'b0; mblank = 1'b0; maddr = '0;
        end else begin
            if (!mhs && !mvs) maddr = '0;
            else if (mblank) maddr = maddr + 1'b1;
            if (mh == RH_TOTAL - 1) begin
                mh = 0;
                mv = (mv == RV_TOTAL - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            mhs    = (mh >= RH_SYNC);
            mvs    = (mv >= RV_SYNC);
            mblank = (mh >= RH_BACK) && (mh < RH_TOTAL - RH_FRONT) &&
                     (mv >= RV_BACK) && (mv < RV_TOTAL - RV_FRONT);
        end
        mx = mblank ? 10'(mh - RH_BACK) : 10'd0;
        my = mblank ? 9'(mv - RV_BACK) : 9'd0;
    endtask

    // driver: one clock of the shrunken instance, expectation queued before the edge
    task automatic drive_cycle();
        logic [EXP_W-1:0] e;
        model_step(rst_n);
        exp_q.push_back({mhs, mvs, mblank, maddr, mx, my});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("hs",      32'(hs),      32'(e[40]));
        check("vs",      32'(vs),      32'(e[39]));
        check("blank_n", 32'(blank_n), 32'(e[38]));
        check("addr",    32'(addr),    32'(e[37:19]));
`ifdef VSG_PIXEL_COORD_EN
        check("x", 32'(x), 32'(e[18:9]));
        check("y", 32'(y), 32'(e[8:0]));
`endif
        if (rst_n && mv == RV_BACK && mh == RH_BACK)
            check("addr_first", 32'(addr), 32'd0);
        if (rst_n && mv == RV_BACK + 1 && mh == RH_BACK)
            check("addr_line2", 32'(addr), 32'(RACT_W));
        if (rst_n && mv == RV_TOTAL - RV_FRONT - 1 && mh == RH_TOTAL - RH_FRONT - 1) begin
            check("addr_last", 32'(addr), 32'(RACT_W * RACT_H - 1));
`ifdef VSG_PIXEL_COORD_EN
            check("x_last", 32'(x), 32'(RACT_W - 1));
            check("y_last", 32'(y), 32'(RACT_H - 1));
`endif
        end
        if (rst_n && mv == RV_TOTAL - 1 && mh == 0)
            check("addr_hold", 32'(addr), 32'(RACT_W * RACT_H));
    endtask

    task automatic run_small();
        int guard;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) drive_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * RH_TOTAL * RV_TOTAL + 5; i++) drive_cycle();
        guard = 0;
        while (!(mv == 8 && mh == 15) && guard < RH_TOTAL * RV_TOTAL) begin
            drive_cycle();
            guard++;
        end
        check("midframe_reach", 32'(guard < RH_TOTAL * RV_TOTAL), 32'd1);
        // asynchronous reset between clock edges
        #1 rst_n = 1'b0;
        #1;
        check("async_hs",      32'(hs),      32'd0);
        check("async_vs",      32'(vs),      32'd0);
        check("async_blank_n", 32'(blank_n), 32'd0);
        check("async_addr",    32'(addr),    32'd0);
        model_step(1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) drive_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < RH_TOTAL * RV_TOTAL + 50; i++) drive_cycle();
    endtask

    task automatic run_default();
        int k_hs_rise = -1, k_hs_fall = -1, k_vs_rise = -1;
        int k_blank_rise = -1, k_blank_fall = -1;
        int addr_at_rise = -1;
        rst_d_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("def_rst_hs",      32'(hs_d),      32'd0);
        check("def_rst_vs",      32'(vs_d),      32'd0);
        check("def_rst_blank_n", 32'(blank_d_n), 32'd0);
        check("def_rst_addr",    32'(addr_d),    32'd0);
        rst_d_n = 1'b1;
        for (int k = 1; k <= 28200; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k_hs_rise < 0 && hs_d) k_hs_rise = k;
            if (k_hs_rise >= 0 && k_hs_fall < 0 && !hs_d) k_hs_fall = k;
            if (k_vs_rise < 0 && vs_d) k_vs_rise = k;
            if (k_blank_rise < 0 && blank_d_n) begin
                k_blank_rise = k;
                addr_at_rise = int'(addr_d);
`ifdef VSG_PIXEL_COORD_EN
                check("def_x_first", 32'(x_d), 32'd0);
                check("def_y_first", 32'(y_d), 32'd0);
`endif
            end
            if (k_blank_rise >= 0 && k_blank_fall < 0 && !blank_d_n) k_blank_fall = k;
            if (k == 27983) check("def_addr_639", 32'(addr_d), 32'd639);
            if (k == 28144) begin
                check("def_blank_line2", 32'(blank_d_n), 32'd1);
                check("def_addr_640",    32'(addr_d),    32'd640);
            end
        end
        check("def_hs_rise",     32'(k_hs_rise),    32'd96);
        check("def_hs_period",   32'(k_hs_fall),    32'd800);
        check("def_vs_rise",     32'(k_vs_rise),    32'd1600);
        check("def_blank_rise",  32'(k_blank_rise), 32'(34 * 800 + 144));
        check("def_blank_width", 32'(k_blank_fall - k_blank_rise), 32'd640);
        check("def_addr_first",  32'(addr_at_rise), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        rst_d_n = 1'b0;
        fork
            run_small();
            run_default();
        join
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
